// File: rtl/cgra_arb_pkg.sv
// Shared types and the round-robin search used by the CGRA output arbiter.
package cgra_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_t;

  // First set bit of req starting at ptr and wrapping; returns ptr when req is empty.
  function automatic logic [IDX_W-1:0] rr_first(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    rr_first = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) rr_first = idx;
    end
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way rotating priority picker.
module rr_pick4
  import cgra_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any
);

  assign grant = rr_first(req, ptr);
  assign any   = |req;

endmodule

// File: rtl/rr_mux_arbiter_4to1.sv
// Round-robin 4:1 arbiter with registered output beat and optional packet lock.
//   state     | meaning
//   ST_IDLE   | all valid requesters compete, rotating priority from ptr
//   ST_LOCKED | only owner may send until it delivers its last beat
module rr_mux_arbiter_4to1
  import cgra_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit LOCK_EN = 1'b1
) (
  input  logic             CGRA_Clock,
  input  logic             CGRA_Reset_n,
  input  logic [3:0]       in_valid,
  input  logic [3:0]       in_last,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       out_src
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [IDX_W-1:0] out_src_q, out_src_d;

  logic [N_REQ-1:0] cand;
  logic [IDX_W-1:0] grant;
  logic             any;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] sel_data;

  rr_pick4 u_pick (
    .req   (cand),
    .ptr   (ptr_q),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    cand = in_valid;
    if (state_q == ST_LOCKED) cand = in_valid & (N_REQ'(1) << owner_q);
  end

  always_comb begin
    sel_data = in_data0;
    case (grant)
      2'd1:    sel_data = in_data1;
      2'd2:    sel_data = in_data2;
      2'd3:    sel_data = in_data3;
      default: sel_data = in_data0;
    endcase
  end

  // cand is a subset of in_valid, so load alone marks a transfer.
  assign can_load = ~out_valid_q | out_ready;
  assign load     = CGRA_Reset_n & can_load & any;
  assign in_ready = load ? (N_REQ'(1) << grant) : '0;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = in_last[grant];
      out_src_d   = grant;
      if (state_q == ST_IDLE) begin
        if (LOCK_EN && !in_last[grant]) begin
          state_d = ST_LOCKED;
          owner_d = grant;
        end else begin
          ptr_d = grant + IDX_W'(1);
        end
      end else if (in_last[grant]) begin
        state_d = ST_IDLE;
        ptr_d   = grant + IDX_W'(1);
      end
    end else if (can_load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CGRA_Clock) begin
    if (!CGRA_Reset_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter_4to1.sv
// Directed bench for rr_mux_arbiter_4to1: one unlocked and one locked instance share the stimulus.
module tb_rr_mux_arbiter_4to1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid, in_last;
  logic [31:0] in_data [4];
  logic        out_ready;

  logic [3:0]  rdy_nl, rdy_lk;
  logic        vld_nl, vld_lk, lst_nl, lst_lk;
  logic [31:0] dat_nl, dat_lk;
  logic [1:0]  src_nl, src_lk;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter_4to1 #(.WIDTH(32), .LOCK_EN(1'b0)) u_nolock (
    .CGRA_Clock(clk), .CGRA_Reset_n(rst_n),
    .in_valid(in_valid), .in_last(in_last),
    .in_data0(in_data[0]), .in_data1(in_data[1]), .in_data2(in_data[2]), .in_data3(in_data[3]),
    .in_ready(rdy_nl), .out_valid(vld_nl), .out_ready(out_ready),
    .out_data(dat_nl), .out_last(lst_nl), .out_src(src_nl)
  );

  rr_mux_arbiter_4to1 #(.WIDTH(32), .LOCK_EN(1'b1)) u_lock (
    .CGRA_Clock(clk), .CGRA_Reset_n(rst_n),
    .in_valid(in_valid), .in_last(in_last),
    .in_data0(in_data[0]), .in_data1(in_data[1]), .in_data2(in_data[2]), .in_data3(in_data[3]),
    .in_ready(rdy_lk), .out_valid(vld_lk), .out_ready(out_ready),
    .out_data(dat_lk), .out_last(lst_lk), .out_src(src_lk)
  );

  // Source-side protocol against the locked instance: an unaccepted beat must stay put.
  logic [3:0]  pv, pr, pl;
  logic [31:0] pd [4];
  logic        prst = 1'b0;
  always @(posedge clk) begin
    if (rst_n && prst)
      for (int i = 0; i < 4; i++)
        if (pv[i] && !pr[i])
          assert (in_valid[i] && in_last[i] == pl[i] && in_data[i] == pd[i])
            else $error("source protocol broken on requester %0d", i);
    pv   <= in_valid;
    pr   <= rdy_lk;
    pl   <= in_last;
    prst <= rst_n;
    for (int i = 0; i < 4; i++) pd[i] <= in_data[i];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 4'h0;
    in_last  = 4'h0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    in_last   = 4'h0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i] = 32'h0;

    // Reset held for 3 clocks with every requester valid
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_lk", 32'(rdy_lk), 32'h0);
    chk("rst_ready_nl", 32'(rdy_nl), 32'h0);
    chk("rst_valid", 32'(vld_lk), 32'h0);
    chk("rst_data", dat_lk, 32'h0);
    chk("rst_src", 32'(src_lk), 32'h0);

    // No lock, all valid: strict rotation, one beat per cycle
    for (int i = 0; i < 4; i++) in_data[i] = 32'hA0 + 32'(i);
    in_last = 4'hF;
    rst_n   = 1'b1;
    #1 chk("t2_ready_first", 32'(rdy_nl), 32'h1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t2_valid", 32'(vld_nl), 32'h1);
      chk("t2_src", 32'(src_nl), 32'(k % 4));
      chk("t2_data", dat_nl, 32'hA0 + 32'(k % 4));
      chk("t2_src_lk", 32'(src_lk), 32'(k % 4));
    end

    // Locked 3-beat packet from req1 while req2 waits
    do_reset();
    in_data[1] = 32'h101;
    in_data[2] = 32'h200;
    in_valid   = 4'b0110;
    #1 chk("t3_rdy_b1", 32'(rdy_lk), 32'b0010);
    cyc();
    chk("t3_src_b1", 32'(src_lk), 32'h1);
    chk("t3_data_b1", dat_lk, 32'h101);
    in_data[1] = 32'h102;
    #1 chk("t3_rdy_b2", 32'(rdy_lk), 32'b0010);
    cyc();
    chk("t3_src_b2", 32'(src_lk), 32'h1);
    chk("t3_data_b2", dat_lk, 32'h102);
    in_data[1] = 32'h103;
    in_last    = 4'b0010;
    #1 chk("t3_rdy_b3", 32'(rdy_lk), 32'b0010);
    cyc();
    chk("t3_src_b3", 32'(src_lk), 32'h1);
    chk("t3_data_b3", dat_lk, 32'h103);
    chk("t3_last_b3", 32'(lst_lk), 32'h1);
    in_valid = 4'b0100;
    in_last  = 4'b0000;
    #1 chk("t3_rdy_req2", 32'(rdy_lk), 32'b0100);
    cyc();
    chk("t3_src_req2", 32'(src_lk), 32'h2);
    chk("t3_data_req2", dat_lk, 32'h200);

    // Backpressure: 4 stalled cycles after the first beat
    do_reset();
    in_valid   = 4'b0001;
    in_last    = 4'b0001;
    in_data[0] = 32'hDEADBEEF;
    #1 chk("t4_rdy_first", 32'(rdy_lk), 32'h1);
    cyc();
    chk("t4_data_first", dat_lk, 32'hDEADBEEF);
    chk("t4_valid_first", 32'(vld_lk), 32'h1);
    out_ready  = 1'b0;
    in_data[0] = 32'hCAFEF00D;
    #1 chk("t4_rdy_stall", 32'(rdy_lk), 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t4_data_hold", dat_lk, 32'hDEADBEEF);
      chk("t4_valid_hold", 32'(vld_lk), 32'h1);
      chk("t4_rdy_hold", 32'(rdy_lk), 32'h0);
    end
    out_ready = 1'b1;
    #1 chk("t4_rdy_release", 32'(rdy_lk), 32'h1);
    cyc();
    chk("t4_data_next", dat_lk, 32'hCAFEF00D);
    chk("t4_valid_next", 32'(vld_lk), 32'h1);
    in_valid = 4'b0000;
    cyc();
    chk("t4_no_dup", 32'(vld_lk), 32'h0);

    // Reset in the middle of a locked packet from req3
    do_reset();
    in_valid   = 4'b1000;
    in_data[3] = 32'h301;
    #1 chk("t5_rdy_b1", 32'(rdy_lk), 32'b1000);
    cyc();
    in_data[3] = 32'h302;
    cyc();
    chk("t5_data_b2", dat_lk, 32'h302);
    chk("t5_src_b2", 32'(src_lk), 32'h3);
    rst_n      = 1'b0;
    in_valid   = 4'b1001;
    in_last    = 4'b0001;
    in_data[0] = 32'h0A;
    in_data[3] = 32'h303;
    #1 chk("t5_rdy_in_rst", 32'(rdy_lk), 32'h0);
    cyc();
    chk("t5_valid_rst", 32'(vld_lk), 32'h0);
    rst_n = 1'b1;
    #1 chk("t5_rdy_after", 32'(rdy_lk), 32'b0001);
    cyc();
    chk("t5_src_after", 32'(src_lk), 32'h0);
    chk("t5_data_after", dat_lk, 32'h0A);

    // Wrap from ptr=3 and skipping idle requesters
    do_reset();
    in_valid   = 4'b0100;
    in_last    = 4'b0100;
    in_data[2] = 32'h22;
    #1 chk("t6_rdy_req2", 32'(rdy_lk), 32'b0100);
    cyc();
    chk("t6_src_req2", 32'(src_lk), 32'h2);
    in_valid   = 4'b0001;
    in_last    = 4'b0001;
    in_data[0] = 32'h30;
    #1 chk("t6_rdy_wrap", 32'(rdy_lk), 32'b0001);
    cyc();
    chk("t6_src_wrap", 32'(src_lk), 32'h0);
    chk("t6_data_wrap", dat_lk, 32'h30);
    in_valid   = 4'b1001;
    in_last    = 4'b1001;
    in_data[0] = 32'h31;
    in_data[3] = 32'h33;
    #1 chk("t6_rdy_skip", 32'(rdy_lk), 32'b1000);
    cyc();
    chk("t6_src_skip", 32'(src_lk), 32'h3);
    chk("t6_data_skip", dat_lk, 32'h33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
